// File: rtl/c_row_checker_if.sv
// Row-checker bus: result row from the MAC array in, streamed words and status out.
// Valid/ready: a word moves on any rising clk where out_valid && out_ready; out_data/out_index hold while stalled.
interface c_row_checker_if #(
    parameter int DATA_W = 32,
    parameter int COLS   = 32,
    parameter int ROWS   = 32
);
    localparam int IDX_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic [(COLS+1)*DATA_W-1:0] dataC_in;
    logic                       MACs_ready;
    logic [DATA_W-1:0]          out_data;
    logic [IDX_W-1:0]           out_index;
    logic                       out_valid;
    logic                       out_ready;
    logic                       row_fault;
    logic [ROW_W-1:0]           fault_row;
    logic [7:0]                 fault_count;
    logic                       overrun;
    logic                       checker_busy;
    logic                       matrix_done;
    logic [2:0]                 dbg_state;
`ifdef C_ROW_CHECKER_FAULT_MAP_EN
    logic [ROWS-1:0]            fault_row_map;
`endif

    modport slave (
        input  dataC_in, MACs_ready, out_ready,
        output out_data, out_index, out_valid, row_fault, fault_row, fault_count,
               overrun, checker_busy, matrix_done, dbg_state
`ifdef C_ROW_CHECKER_FAULT_MAP_EN
        , output fault_row_map
`endif
    );

    modport master (
        output dataC_in, MACs_ready, out_ready,
        input  out_data, out_index, out_valid, row_fault, fault_row, fault_count,
               overrun, checker_busy, matrix_done, dbg_state
`ifdef C_ROW_CHECKER_FAULT_MAP_EN
        , input fault_row_map
`endif
    );
endinterface

// File: rtl/c_row_checker.sv
// Captures each MAC result row, re-adds its 32 words against the checksum word, streams the words out.
// Optional per-row fault bitmap when C_ROW_CHECKER_FAULT_MAP_EN is defined.
module c_row_checker #(
    parameter int DATA_W = 32,
    parameter int COLS   = 32,
    parameter int ROWS   = 32
) (
    input logic            clk,
    input logic            checker_reset,
    c_row_checker_if.slave bus
);
    localparam int IDX_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, SUM, CHECK, OUT, DONE_ROW} state_e;

    state_e                     state_q;
    logic                       ready_q;
    logic                       rise;
    logic [(COLS+1)*DATA_W-1:0] row_q;
    logic [DATA_W-1:0]          acc_q;
    logic [IDX_W-1:0]           idx_q;
    logic [ROW_W-1:0]           row_cnt_q;
    logic [DATA_W-1:0]          out_data_q;
    logic [IDX_W-1:0]           out_index_q;
    logic                       out_valid_q;
    logic                       row_fault_q;
    logic [ROW_W-1:0]           fault_row_q;
    logic [7:0]                 fault_count_q;
    logic                       overrun_q;
    logic                       busy_q;
    logic                       matrix_done_q;
`ifdef C_ROW_CHECKER_FAULT_MAP_EN
    logic [ROWS-1:0]            map_q;
`endif

    assign rise = bus.MACs_ready & ~ready_q;

    function automatic logic [DATA_W-1:0] word(input int k);
        return row_q[k*DATA_W +: DATA_W];
    endfunction

    always_ff @(posedge clk) begin
        if (checker_reset) begin
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            row_q         <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            row_cnt_q     <= '0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            out_valid_q   <= 1'b0;
            row_fault_q   <= 1'b0;
            fault_row_q   <= '0;
            fault_count_q <= '0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
            matrix_done_q <= 1'b0;
`ifdef C_ROW_CHECKER_FAULT_MAP_EN
            map_q         <= '0;
`endif
        end else begin
            ready_q       <= bus.MACs_ready;
            row_fault_q   <= 1'b0;
            matrix_done_q <= 1'b0;
            // A row offered while one is in flight is dropped, only flagged.
            if (rise && state_q != IDLE) overrun_q <= 1'b1;
`ifdef C_ROW_CHECKER_FAULT_MAP_EN
            // Cleared one cycle late so the final row's bit is seen alongside matrix_done.
            if (matrix_done_q) map_q <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        row_q   <= bus.dataC_in;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SUM;
                    end
                end
                SUM: begin
                    acc_q <= acc_q + word(int'(idx_q));
                    if (idx_q == IDX_LAST) begin
                        idx_q   <= '0;
                        state_q <= CHECK;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (acc_q != word(COLS)) begin
                        row_fault_q <= 1'b1;
                        fault_row_q <= row_cnt_q;
                        if (fault_count_q != 8'hFF) fault_count_q <= fault_count_q + 8'd1;
`ifdef C_ROW_CHECKER_FAULT_MAP_EN
                        map_q[row_cnt_q] <= 1'b1;
`endif
                    end
                    out_valid_q <= 1'b1;
                    out_data_q  <= word(0);
                    out_index_q <= '0;
                    idx_q       <= '0;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_valid_q && bus.out_ready) begin
                        if (idx_q == IDX_LAST) begin
                            out_valid_q <= 1'b0;
                            state_q     <= DONE_ROW;
                        end else begin
                            idx_q       <= idx_q + 1'b1;
                            out_index_q <= idx_q + 1'b1;
                            out_data_q  <= word(int'(idx_q) + 1);
                        end
                    end
                end
                DONE_ROW: begin
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_q     <= '0;
                        fault_count_q <= '0;
                        matrix_done_q <= 1'b1;
                    end else begin
                        row_cnt_q <= row_cnt_q + 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_data     = out_data_q;
    assign bus.out_index    = out_index_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.row_fault    = row_fault_q;
    assign bus.fault_row    = fault_row_q;
    assign bus.fault_count  = fault_count_q;
    assign bus.overrun      = overrun_q;
    assign bus.checker_busy = busy_q;
    assign bus.matrix_done  = matrix_done_q;
    assign bus.dbg_state    = state_q;
`ifdef C_ROW_CHECKER_FAULT_MAP_EN
    assign bus.fault_row_map = map_q;
`endif
endmodule
